// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Write-side producer for a ping-pong window memory. Takes a row-major pixel
//   stream of an IMAGE_SIZE x IMAGE_SIZE image and keeps the two previous rows
//   in line buffers. From row 2 onward, every accepted pixel produces one
//   vertical triplet (rows r-2, r-1, r). Each triplet is written into bank 1 or
//   bank 2. Each bank takes COLUMNS triplets, then writing moves to the other
//   bank. The stream stalls while the bank being written is still full.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   pix_in/pix_valid       input pixel stream
//   pix_ready              pixel accepted when pix_valid & pix_ready
//   write_enable_1/2       one-cycle write strobe for bank 1 / bank 2
//   data_outputA1..A3      bank-1 triplet (rows r-2, r-1, r)
//   data_outputB1..B3      bank-2 triplet (rows r-2, r-1, r)
//   bank_release_1/2       reader pulse: bank drained
//   bank_full_1/2          bank holds COLUMNS unread triplets
//   frame_done             pulses with the last triplet of a frame
module conv_window_feeder #(
  parameter int unsigned IMAGE_SIZE  = 16,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COLUMNS     = 4,
  parameter int unsigned ROWS        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  write_enable_1,
  output logic                  write_enable_2,
  output logic [DATA_WIDTH-1:0] data_outputA1,
  output logic [DATA_WIDTH-1:0] data_outputA2,
  output logic [DATA_WIDTH-1:0] data_outputA3,
  output logic [DATA_WIDTH-1:0] data_outputB1,
  output logic [DATA_WIDTH-1:0] data_outputB2,
  output logic [DATA_WIDTH-1:0] data_outputB3,
  input  logic                  bank_release_1,
  input  logic                  bank_release_2,
  output logic                  bank_full_1,
  output logic                  bank_full_2,
  output logic                  frame_done
);

  localparam int unsigned CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned BW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_SIZE - 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(COLUMNS - 1);

  if (KERNEL_SIZE != 3 || ROWS != KERNEL_SIZE) begin : g_bad_kernel
    $error("conv_window_feeder supports only a 3-row kernel");
  end
  if (IMAGE_SIZE % COLUMNS != 0) begin : g_bad_columns
    $error("IMAGE_SIZE must be a multiple of COLUMNS");
  end

  typedef enum logic {
    BANK_1 = 1'b0,
    BANK_2 = 1'b1
  } bank_t;

  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  bank_t                 active_bank;
  logic [BW-1:0]         bank_cnt;
  logic [DATA_WIDTH-1:0] lb0 [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] lb1 [IMAGE_SIZE];

  logic active_full;
  logic accept;
  logic emit;
  logic bank_wrap;
  logic set_1;
  logic set_2;

  always_comb begin
    active_full = (active_bank == BANK_1) ? bank_full_1 : bank_full_2;
    // Rows 0 and 1 only fill the line buffers, so they never wait for a bank.
    pix_ready   = reset & ((row < CW'(2)) | ~active_full);
    accept      = pix_valid & pix_ready;
    emit        = accept & (row >= CW'(2));
    bank_wrap   = emit & (bank_cnt == LAST_CNT);
    set_1       = bank_wrap & (active_bank == BANK_1);
    set_2       = bank_wrap & (active_bank == BANK_2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row            <= '0;
      col            <= '0;
      active_bank    <= BANK_1;
      bank_cnt       <= '0;
      write_enable_1 <= 1'b0;
      write_enable_2 <= 1'b0;
      data_outputA1  <= '0;
      data_outputA2  <= '0;
      data_outputA3  <= '0;
      data_outputB1  <= '0;
      data_outputB2  <= '0;
      data_outputB3  <= '0;
      bank_full_1    <= 1'b0;
      bank_full_2    <= 1'b0;
      frame_done     <= 1'b0;
      for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
    end else begin
      write_enable_1 <= 1'b0;
      write_enable_2 <= 1'b0;
      frame_done     <= 1'b0;

      if (accept) begin
        lb0[col] <= lb1[col];
        lb1[col] <= pix_in;
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (emit) begin
        if (active_bank == BANK_1) begin
          data_outputA1  <= lb0[col];
          data_outputA2  <= lb1[col];
          data_outputA3  <= pix_in;
          write_enable_1 <= 1'b1;
        end else begin
          data_outputB1  <= lb0[col];
          data_outputB2  <= lb1[col];
          data_outputB3  <= pix_in;
          write_enable_2 <= 1'b1;
        end
        if (bank_cnt == LAST_CNT) begin
          bank_cnt    <= '0;
          active_bank <= (active_bank == BANK_1) ? BANK_2 : BANK_1;
        end else begin
          bank_cnt <= bank_cnt + 1'b1;
        end
        frame_done <= (row == LAST_IDX) && (col == LAST_IDX);
      end

      // A fill in the same cycle as a release takes priority, so the new
      // contents are never lost.
      if (set_1)               bank_full_1 <= 1'b1;
      else if (bank_release_1) bank_full_1 <= 1'b0;
      if (set_2)               bank_full_2 <= 1'b1;
      else if (bank_release_2) bank_full_2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Testbench for conv_window_feeder: a table of directed vectors for bank
// filling and stalls, hand-written reset/release sequences, and a random phase.
// A frame-level reference model (image array plus a triplet count) runs
// alongside every cycle.
module tb_conv_window_feeder;
  localparam int IS = 16;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       bank_release_1 = 1'b0;
  logic       bank_release_2 = 1'b0;
  logic       pix_ready, write_enable_1, write_enable_2;
  logic [7:0] data_outputA1, data_outputA2, data_outputA3;
  logic [7:0] data_outputB1, data_outputB2, data_outputB3;
  logic       bank_full_1, bank_full_2, frame_done;

  conv_window_feeder #(.IMAGE_SIZE(16), .KERNEL_SIZE(3), .DATA_WIDTH(8), .COLUMNS(4), .ROWS(3)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .data_outputA1(data_outputA1), .data_outputA2(data_outputA2), .data_outputA3(data_outputA3),
    .data_outputB1(data_outputB1), .data_outputB2(data_outputB2), .data_outputB3(data_outputB3),
    .bank_release_1(bank_release_1), .bank_release_2(bank_release_2),
    .bank_full_1(bank_full_1), .bank_full_2(bank_full_2), .frame_done(frame_done));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pixel position in frame, image of the current frame,
  // number of triplets since reset (bank = (count / COLUMNS) mod 2).
  int         m_pos, m_trip;
  logic [7:0] img [IS][IS];
  bit         m_full [2];
  bit         m_set  [2];
  logic [7:0] m_a [3];
  logic [7:0] m_b [3];
  bit         m_we1, m_we2, m_fd, m_acc;

  function automatic bit m_ready();
    return (m_pos / IS < 2) || !m_full[(m_trip / NC) % 2];
  endfunction

  task automatic model_reset();
    m_pos = 0; m_trip = 0;
    m_we1 = 0; m_we2 = 0; m_fd = 0; m_acc = 0;
    for (int i = 0; i < 2; i++) begin m_full[i] = 0; m_set[i] = 0; end
    for (int i = 0; i < 3; i++) begin m_a[i] = '0; m_b[i] = '0; end
    for (int r = 0; r < IS; r++) for (int c = 0; c < IS; c++) img[r][c] = '0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] p, input bit r1, input bit r2);
    int r, c, bk;
    bit s0, s1;
    s0 = 0; s1 = 0;
    m_acc = v && m_ready();
    m_we1 = 0; m_we2 = 0; m_fd = 0;
    if (m_acc) begin
      r = m_pos / IS; c = m_pos % IS;
      img[r][c] = p;
      if (r >= 2) begin
        bk = (m_trip / NC) % 2;
        if (bk == 0) begin
          m_a[0] = img[r-2][c]; m_a[1] = img[r-1][c]; m_a[2] = p; m_we1 = 1;
        end else begin
          m_b[0] = img[r-2][c]; m_b[1] = img[r-1][c]; m_b[2] = p; m_we2 = 1;
        end
        m_trip++;
        if (m_trip % NC == 0) begin
          m_full[bk] = 1;
          if (bk == 0) s0 = 1; else s1 = 1;
        end
        m_fd = (r == IS-1) && (c == IS-1);
      end
      m_pos = (m_pos + 1) % (IS * IS);
    end
    if (r1 && !s0) m_full[0] = 0;
    if (r2 && !s1) m_full[1] = 0;
    m_set[0] = s0; m_set[1] = s1;
  endtask

  bit         last_ready;
  int         we_cnt, fd_cnt, acc_cnt;
  logic [23:0] fd_trip;

  task automatic step(input bit v, input logic [7:0] p, input bit r1, input bit r2);
    @(negedge clk);
    pix_valid = v; pix_in = p; bank_release_1 = r1; bank_release_2 = r2;
    #1;
    last_ready = pix_ready;
    chk("pix_ready", pix_ready, m_ready());
    @(posedge clk);
    model_edge(v, p, r1, r2);
    #1;
    chk("write_enable_1", write_enable_1, m_we1);
    chk("write_enable_2", write_enable_2, m_we2);
    chk("one_enable", write_enable_1 & write_enable_2, 0);
    chk("frame_done", frame_done, m_fd);
    chk("bank_full_1", bank_full_1, m_full[0]);
    chk("bank_full_2", bank_full_2, m_full[1]);
    chk("A1", data_outputA1, m_a[0]); chk("A2", data_outputA2, m_a[1]); chk("A3", data_outputA3, m_a[2]);
    chk("B1", data_outputB1, m_b[0]); chk("B2", data_outputB2, m_b[1]); chk("B3", data_outputB3, m_b[2]);
    we_cnt += int'(write_enable_1) + int'(write_enable_2);
    if (m_acc) acc_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_trip = write_enable_1 ? {data_outputA1, data_outputA2, data_outputA3}
                               : {data_outputB1, data_outputB2, data_outputB3};
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_we"}, {write_enable_1, write_enable_2, frame_done}, 0);
    chk({tag, "_full"}, {bank_full_1, bank_full_2}, 0);
    chk({tag, "_dataA"}, {data_outputA1, data_outputA2, data_outputA3}, 0);
    chk({tag, "_dataB"}, {data_outputB1, data_outputB2, data_outputB3}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; pix_valid = 0; bank_release_1 = 0; bank_release_2 = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check_zero("reset");
    end
    @(negedge clk);
    reset = 1;
    #1;
    chk("ready_after_reset", pix_ready, 1);
    chk("full_after_reset", {bank_full_1, bank_full_2}, 0);
  endtask

  typedef struct {
    bit v; logic [7:0] p; bit r1, r2;
    bit rdy, we1, we2;
    logic [7:0] d1, d2, d3;
    bit f1, f2;
  } vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 8'd32, 0, 0, 1, 1, 0, 8'd0, 8'd16, 8'd32, 0, 0};
    tbl[1] = '{1, 8'd33, 0, 0, 1, 1, 0, 8'd1, 8'd17, 8'd33, 0, 0};
    tbl[2] = '{1, 8'd34, 0, 0, 1, 1, 0, 8'd2, 8'd18, 8'd34, 0, 0};
    tbl[3] = '{1, 8'd35, 0, 0, 1, 1, 0, 8'd3, 8'd19, 8'd35, 1, 0};
    tbl[4] = '{1, 8'd36, 0, 0, 1, 0, 1, 8'd4, 8'd20, 8'd36, 1, 0};
    tbl[5] = '{1, 8'd37, 0, 0, 1, 0, 1, 8'd5, 8'd21, 8'd37, 1, 0};
    tbl[6] = '{1, 8'd38, 0, 0, 1, 0, 1, 8'd6, 8'd22, 8'd38, 1, 0};
    tbl[7] = '{1, 8'd39, 0, 0, 1, 0, 1, 8'd7, 8'd23, 8'd39, 1, 1};
    tbl[8] = '{1, 8'd40, 1, 0, 0, 0, 0, 8'd0, 8'd0,  8'd0,  0, 1};
    tbl[9] = '{1, 8'd40, 0, 0, 1, 1, 0, 8'd8, 8'd24, 8'd40, 0, 1};

    model_reset();
    we_cnt = 0; fd_cnt = 0; acc_cnt = 0; fd_trip = '0;

    // Reset state and rows 0-1.
    do_reset();
    we_cnt = 0;
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0);
    chk("rows01_enables", we_cnt, 0);

    // Bank filling, stall and release.
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].p, tbl[i].r1, tbl[i].r2);
      chk("tbl_ready", last_ready, tbl[i].rdy);
      chk("tbl_we1", write_enable_1, tbl[i].we1);
      chk("tbl_we2", write_enable_2, tbl[i].we2);
      if (tbl[i].we1) chk("tbl_A", {data_outputA1, data_outputA2, data_outputA3}, {tbl[i].d1, tbl[i].d2, tbl[i].d3});
      if (tbl[i].we2) chk("tbl_B", {data_outputB1, data_outputB2, data_outputB3}, {tbl[i].d1, tbl[i].d2, tbl[i].d3});
      chk("tbl_full", {bank_full_1, bank_full_2}, {tbl[i].f1, tbl[i].f2});
    end

    // Same-cycle set and release on bank 2: the set wins.
    for (int i = 41; i <= 43; i++) step(1, 8'(i), 0, 0);
    chk("stall_bank2_full", {bank_full_1, bank_full_2}, 2'b11);
    step(1, 8'd44, 0, 1);
    chk("stalled_on_44", last_ready, 0);
    for (int i = 44; i <= 46; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd47, 0, 1);
    chk("set_wins_we2", write_enable_2, 1);
    chk("set_wins_full2", bank_full_2, 1);

    // Full frame, valid toggling, each bank released one cycle after filling.
    do_reset();
    we_cnt = 0; fd_cnt = 0; acc_cnt = 0;
    for (int cyc = 0; cyc < 2000 && acc_cnt < 256; cyc++)
      step(cyc % 2 == 0, 8'(m_pos), m_set[0], m_set[1]);
    chk("frame_accepts", acc_cnt, 256);
    chk("frame_enables", we_cnt, 224);
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_triplet", fd_trip, {8'd223, 8'd239, 8'd255});
    we_cnt = 0; acc_cnt = 0;
    for (int cyc = 0; cyc < 500 && acc_cnt < 32; cyc++)
      step(cyc % 2 == 0, 8'(m_pos), m_set[0], m_set[1]);
    chk("next_rows01_accepts", acc_cnt, 32);
    chk("next_rows01_enables", we_cnt, 0);

    // Reset at row 5, col 6 with bank 1 left full.
    do_reset();
    for (int cyc = 0; cyc < 500 && m_pos != 86; cyc++)
      step(1, 8'(m_pos), (m_pos < 80) && m_set[0], m_set[1]);
    chk("reached_r5c6", m_pos, 86);
    chk("full1_before_reset", bank_full_1, 1);
    @(negedge clk);
    #2 reset = 0;
    model_reset();
    #1 check_zero("async_reset");
    @(negedge clk);
    pix_valid = 0; bank_release_1 = 0; bank_release_2 = 0;
    @(negedge clk);
    reset = 1;
    we_cnt = 0;
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0);
    chk("restream_rows01_enables", we_cnt, 0);
    step(1, 8'd32, 0, 0);
    chk("restream_we1", write_enable_1, 1);
    chk("restream_A", {data_outputA1, data_outputA2, data_outputA3}, {8'd0, 8'd16, 8'd32});

    // Random data, valid and releases against the model.
    for (int cyc = 0; cyc < 3000; cyc++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Write-side producer for the ping-pong window memory.
- Accepts a row-major pixel stream of an IMAGE_SIZE x IMAGE_SIZE image and keeps the two previous image rows in internal line buffers.
- Emits 3-pixel vertical column triplets (rows r-2, r-1, r) into bank 1 or bank 2, COLUMNS triplets per bank, alternating banks.
- Stalls the stream when the target bank has not yet been released by the read side.

Parameters:
IMAGE_SIZE, 16, image width and height in pixels; must be a multiple of COLUMNS.
KERNEL_SIZE, 3, window height; only 3 is supported.
DATA_WIDTH, 8, pixel width in bits.
COLUMNS, 4, triplets stored per bank.
ROWS, 3, rows per triplet; equals KERNEL_SIZE.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
pix_in  in  DATA_WIDTH  stream pixel.
pix_valid  in  1  pix_in is valid.
pix_ready  out  1  block accepts pix_in this cycle.
write_enable_1  out  1  triplet on data_outputA1..A3 is written to bank 1.
write_enable_2  out  1  triplet on data_outputB1..B3 is written to bank 2.
data_outputA1/A2/A3  out  DATA_WIDTH each  bank-1 triplet: rows r-2, r-1, r.
data_outputB1/B2/B3  out  DATA_WIDTH each  bank-2 triplet: rows r-2, r-1, r.
bank_release_1  in  1  one-cycle pulse from the reader: bank 1 drained.
bank_release_2  in  1  one-cycle pulse from the reader: bank 2 drained.
bank_full_1  out  1  bank 1 holds COLUMNS unread triplets.
bank_full_2  out  1  bank 2 holds COLUMNS unread triplets.
frame_done  out  1  one-cycle pulse after the final triplet of a frame.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0; pix_ready forced 0 while reset is low.
  - Row and column counters 0; active bank = 1; bank_full_1/2 = 0.
  - Line buffers lb0 and lb1 (IMAGE_SIZE entries each) cleared to 0.
- Accept: pix_valid & pix_ready at the rising edge.
- pix_ready:
  - 1 for rows 0 and 1.
  - From row 2 onward, 1 only when the active bank is not full.
- Line buffer update on accept at column c:
  - Triplet = (lb0[c], lb1[c], pix_in).
  - lb0[c] <= lb1[c]; lb1[c] <= pix_in.
- Emission:
  - Only when row >= 2.
  - Latency 1 cycle: the triplet appears registered on the active bank's data outputs, with that bank's write_enable high for exactly one cycle.
  - The other bank's enable stays 0; its data outputs hold their previous value.
  - At most one enable is high in any cycle.
- Bank counter: counts emitted triplets (0..COLUMNS-1). On the COLUMNS-th write to the active bank, in the same edge:
  - That bank's bank_full is set.
  - The counter wraps to 0.
  - The active bank toggles.
- Release:
  - bank_release_x clears bank_full_x on the next edge.
  - A release to a non-full bank is ignored.
  - If a release and the setting write land on the same bank in the same cycle, the set wins and the release is ignored.
- Counters:
  - col increments on every accept and wraps at IMAGE_SIZE-1, incrementing row.
  - row wraps at IMAGE_SIZE-1 to 0, which starts the next frame.
  - Line buffers are not cleared between frames; rows 0 and 1 of the new frame overwrite them and emit nothing.
- frame_done: pulses in the same cycle as the write_enable of the triplet for (row IMAGE_SIZE-1, col IMAGE_SIZE-1).
- Bank fills per frame: (IMAGE_SIZE-2) x IMAGE_SIZE / COLUMNS; 56 at defaults. Partial banks cannot occur.
- Stall: while pix_ready is 0, no state changes except release handling; pix_in is ignored.
- Reset mid-frame discards partial rows and bank contents status; streaming restarts at row 0, col 0 with bank 1.

Test Plan:
Stimulus pixel value = (row x 16 + col) mod 256; releases pulsed where stated.
1. Hold reset low 3 cycles -> all outputs 0, pix_ready 0; release reset -> pix_ready 1, bank_full_1/2 0.
2. Stream rows 0-1 (32 pixels, valid every cycle) -> no write enable. Accept pixel 32 (row 2, col 0) -> next cycle write_enable_1=1 with A1=0, A2=16, A3=32.
3. Continue row 2 with no releases:
   - Cols 0-3 go to bank 1; bank_full_1=1 after col 3.
   - Cols 4-7 go to bank 2, first B = (4, 20, 36); bank_full_2=1.
   - Pixel 40 stalls with pix_ready=0.
   - Pulse bank_release_1 -> pix_ready=1 next cycle; pixel 40 is written to bank 1 as (8, 24, 40).
4. Same-cycle set/release: pulse bank_release_2 in the cycle bank 2 receives its 4th triplet -> bank_full_2 remains 1.
5. Full frame with each bank released one cycle after it fills, pix_valid toggling 1/0 -> exactly 224 write enables, no enable on idle cycles, and frame_done pulsed once alongside the triplet (223, 239, 255). The following rows 0-1 produce no enables.
6. Assert reset at row 5, col 6 with bank_full_1=1 -> all state is 0 and bank_full is cleared. Restreaming from pixel 0 reproduces scenario 2 values.
